// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS pipeline front end.
//   - Datapath widths and the sequential PC step.
//   - Opcode / funct constants decode uses when it forms redirects.
//   - fetch_entry_t: one buffered fetch, {pc, instr}, 64 bits packed.
//   - Helper functions for PC arithmetic.
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;
    localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

    localparam logic [5:0] OP_J           = 6'h02;
    localparam logic [5:0] OP_JAL         = 6'h03;
    localparam logic [5:0] OP_BEQ         = 6'h04;
    localparam logic [5:0] RTYPE_FUNCT_JR = 6'h08;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Next sequential PC; the 32-bit add wraps FFFFFFFC to 00000000.
    function automatic logic [ADDR_W-1:0] pc_next_seq(input logic [ADDR_W-1:0] pc);
        pc_next_seq = pc + PC_STEP;
    endfunction

    // Word-align a redirect target by clearing the byte-offset bits.
    function automatic logic [ADDR_W-1:0] pc_align(input logic [ADDR_W-1:0] addr);
        pc_align = addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Small circular buffer holding fetched {pc, instr} words.
// Ports:
//   clk, reset   : clock and synchronous active-high reset
//   push         : write wr_data at the write pointer
//   pop          : retire the head entry
//   flush        : discard all entries (count and both pointers to zero)
//   wr_data      : entry to write
//   head         : entry at the read pointer (combinational)
//   count        : occupancy, 0..DEPTH
// A push while full is accepted only when a pop frees the slot in the same
// cycle; a pop while empty is ignored. DEPTH must be a power of two so the
// pointers wrap naturally.
// ---------------------------------------------------------------------------
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             pop_ok_s;
    logic             push_ok_s;

    // Qualify push/pop against current occupancy.
    always_comb begin
        pop_ok_s  = 1'b0;
        push_ok_s = 1'b0;
        if (pop && (count_r != {CNT_W{1'b0}})) begin
            pop_ok_s = 1'b1;
        end else begin
            pop_ok_s = 1'b0;
        end
        if (push && ((count_r < CNT_W'(DEPTH)) || pop_ok_s)) begin
            push_ok_s = 1'b1;
        end else begin
            push_ok_s = 1'b0;
        end
    end

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok_s && !reset && !flush) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/ifetch_ctrl.sv
// ---------------------------------------------------------------------------
// ifetch_ctrl
// Instruction-fetch sequencer: owns the PC, drives the combinational
// InstructionMemory address, buffers fetched words and hands them to decode
// with a valid/ready handshake. Redirects flush the buffer and reload the PC.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   imem_addr/data    : InstructionMemory address (== PC) and returned word
//   redirect_valid/pc : taken branch / jump and its target (bits [1:0] ignored)
//   out_valid/ready   : handshake toward decode
//   out_instr/pc/pc_plus4 : head instruction, its address, and address + 4
//   flush_count       : redirects since reset, saturating at FFFF
// ---------------------------------------------------------------------------
module ifetch_ctrl
    import mips_pkg::*;
#(
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [ADDR_W-1:0]  out_pc_plus4,
    output logic [15:0]        flush_count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] pc_r;
    logic [15:0]       flush_count_r;
    fetch_entry_t      hold_r;
    fetch_entry_t      head_s;
    fetch_entry_t      view_s;
    fetch_entry_t      wr_entry_s;
    logic [CNT_W-1:0]  count_s;
    logic              pop_s;
    logic              push_s;
    logic              valid_s;

    // Handshake and fetch qualification. The redirect mask on valid means no
    // instruction is consumed in the cycle its successors are being squashed.
    always_comb begin
        valid_s = 1'b0;
        pop_s   = 1'b0;
        push_s  = 1'b0;
        if ((count_s != {CNT_W{1'b0}}) && !redirect_valid) begin
            valid_s = 1'b1;
        end else begin
            valid_s = 1'b0;
        end
        pop_s = valid_s && out_ready;
        if (!reset && !redirect_valid && ((count_s < CNT_W'(DEPTH)) || pop_s)) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
    end

    // Head view: live buffer head when non-empty, otherwise the last head seen.
    always_comb begin
        view_s = hold_r;
        if (count_s != {CNT_W{1'b0}}) begin
            view_s = head_s;
        end else begin
            view_s = hold_r;
        end
    end

    assign wr_entry_s = '{pc: pc_r, instr: imem_data};

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + INSTR_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push_s),
        .pop     (pop_s),
        .flush   (redirect_valid),
        .wr_data (wr_entry_s),
        .head    (head_s),
        .count   (count_s)
    );

    // Program counter: reset, redirect, sequential advance on push, or hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r <= RESET_PC;
        end else if (redirect_valid) begin
            pc_r <= pc_align(redirect_pc);
        end else if (push_s) begin
            pc_r <= pc_next_seq(pc_r);
        end else begin
            pc_r <= pc_r;
        end
    end

    // Saturating redirect counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_count_r <= 16'h0000;
        end else if (redirect_valid && (flush_count_r != 16'hFFFF)) begin
            flush_count_r <= flush_count_r + 16'd1;
        end else begin
            flush_count_r <= flush_count_r;
        end
    end

    // Remember the most recent head so the output fields hold when empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_r <= '{pc: 32'h0000_0000, instr: 32'h0000_0000};
        end else if (count_s != {CNT_W{1'b0}}) begin
            hold_r <= head_s;
        end else begin
            hold_r <= hold_r;
        end
    end

    assign imem_addr    = pc_r;
    assign out_valid    = valid_s;
    assign out_instr    = view_s.instr;
    assign out_pc       = view_s.pc;
    assign out_pc_plus4 = pc_next_seq(view_s.pc);
    assign flush_count  = flush_count_r;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ifetch_ctrl
// Scoreboard bench: stimulus pushes expected {pc, instr} into a queue and a
// monitor process compares every completed handshake against the queue head.
// A second instance with RESET_PC = FFFFFFFC covers the PC wrap.
// ---------------------------------------------------------------------------
module tb_ifetch_ctrl;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic [15:0] flush_count;

    logic        reset_w;
    logic [31:0] imem_addr_w;
    logic [31:0] imem_data_w;
    logic        out_valid_w;
    logic        out_ready_w;
    logic [31:0] out_instr_w;
    logic [31:0] out_pc_w;
    logic [31:0] out_pc_plus4_w;
    logic [15:0] flush_count_w;

    int errors;
    int checks;
    exp_t exp_q[$];

    // Program image: word 0 and word 4 as given, other low words distinct,
    // everything outside the program reads as nop (0).
    function automatic logic [31:0] rom(input logic [7:0] idx);
        case (idx)
            8'd0:    rom = 32'h2004_0005;
            8'd4:    rom = 32'h23BD_FFF8;
            default: rom = (idx < 8'd16) ? (32'h3C01_0000 | {24'h0, idx}) : 32'h0;
        endcase
    endfunction

    assign imem_data   = rom(imem_addr[9:2]);
    assign imem_data_w = rom(imem_addr_w[9:2]);

    ifetch_ctrl #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4),
        .flush_count    (flush_count)
    );

    ifetch_ctrl #(.DEPTH(2), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk            (clk),
        .reset          (reset_w),
        .imem_addr      (imem_addr_w),
        .imem_data      (imem_data_w),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0000_0000),
        .out_valid      (out_valid_w),
        .out_ready      (out_ready_w),
        .out_instr      (out_instr_w),
        .out_pc         (out_pc_w),
        .out_pc_plus4   (out_pc_plus4_w),
        .flush_count    (flush_count_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pc(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = rom(pc[9:2]);
        exp_q.push_back(e);
    endtask

    // Wait (bounded) until the monitor has consumed every expected entry.
    task automatic wait_drain(input string name);
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check(name, exp_q.size(), 32'd0);
    endtask

    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop: got pc %h, expected no handshake", out_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("mon_pc", out_pc, e.pc);
                    check("mon_instr", out_instr, e.instr);
                    check("mon_pc_plus4", out_pc_plus4, e.pc + 32'd4);
                end
            end
        end
    endtask

    task automatic apply_reset();
        reset          = 1'b1;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        tick();
        tick();
        check("rst_valid", {31'h0, out_valid}, 32'd0);
        check("rst_pc", out_pc, 32'h0);
        check("rst_instr", out_instr, 32'h0);
        check("rst_pc_plus4", out_pc_plus4, 32'h4);
        check("rst_flush_count", {16'h0, flush_count}, 32'd0);
        check("rst_imem_addr", imem_addr, 32'h0);
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        reset          = 1'b1;
        reset_w        = 1'b1;
        out_ready      = 1'b0;
        out_ready_w    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        fork
            monitor_loop();
        join_none

        // 1: streaming after reset
        apply_reset();
        for (int i = 0; i < 6; i++) expect_pc(32'(i * 4));
        reset     = 1'b0;
        out_ready = 1'b1;
        tick();
        check("t1_valid_latency", {31'h0, out_valid}, 32'd1);
        check("t1_first_instr", out_instr, 32'h2004_0005);
        wait_drain("t1_drain");
        out_ready = 1'b0;

        // 2: back-pressure
        apply_reset();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("t2_imem_hold", imem_addr, 32'h8);
        check("t2_head_pc", out_pc, 32'h0);
        expect_pc(32'h0);
        expect_pc(32'h4);
        expect_pc(32'h8);
        out_ready = 1'b1;
        wait_drain("t2_drain");
        out_ready = 1'b0;

        // 3: redirect with a full buffer and ready high
        apply_reset();
        reset = 1'b0;
        tick();
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0010;
        out_ready      = 1'b1;
        #1;
        check("t3_valid_masked", {31'h0, out_valid}, 32'd0);
        expect_pc(32'h10);
        expect_pc(32'h14);
        tick();
        redirect_valid = 1'b0;
        check("t3_flush_count", {16'h0, flush_count}, 32'd1);
        check("t3_fetch_addr", imem_addr, 32'h10);
        check("t3_valid_gap", {31'h0, out_valid}, 32'd0);
        tick();
        check("t3_target_valid", {31'h0, out_valid}, 32'd1);
        check("t3_target_instr", out_instr, 32'h23BD_FFF8);
        wait_drain("t3_drain");
        out_ready = 1'b0;

        // 4: misaligned redirect target
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0017;
        expect_pc(32'h14);
        tick();
        redirect_valid = 1'b0;
        check("t4_fetch_addr", imem_addr, 32'h14);
        check("t4_flush_count", {16'h0, flush_count}, 32'd2);
        out_ready = 1'b1;
        wait_drain("t4_drain");
        out_ready = 1'b0;

        // 5: PC wrap on the second instance
        reset_w     = 1'b0;
        out_ready_w = 1'b0;
        tick();
        check("t5_wrap_addr", imem_addr_w, 32'h0);
        tick();
        check("t5_valid", {31'h0, out_valid_w}, 32'd1);
        check("t5_pc_first", out_pc_w, 32'hFFFF_FFFC);
        check("t5_plus4_first", out_pc_plus4_w, 32'h0);
        check("t5_instr_first", out_instr_w, 32'h0);
        out_ready_w = 1'b1;
        tick();
        out_ready_w = 1'b0;
        check("t5_pc_second", out_pc_w, 32'h0);
        check("t5_plus4_second", out_pc_plus4_w, 32'h4);
        check("t5_instr_second", out_instr_w, 32'h2004_0005);

        // 6: reset mid-stream with two entries buffered and PC = 0x20
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0018;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        check("t6_pre_addr", imem_addr, 32'h20);
        check("t6_pre_valid", {31'h0, out_valid}, 32'd1);
        check("t6_pre_flush_count", {16'h0, flush_count}, 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_post_valid", {31'h0, out_valid}, 32'd0);
        check("t6_post_flush_count", {16'h0, flush_count}, 32'd0);
        check("t6_post_addr", imem_addr, 32'h0);
        expect_pc(32'h0);
        expect_pc(32'h4);
        out_ready = 1'b1;
        wait_drain("t6_drain");
        out_ready = 1'b0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
- Instruction-fetch sequencer for the MIPS pipeline.
- Owns the PC and drives the combinational InstructionMemory address. It buffers fetched words in a small FIFO and presents them to decode with a valid/ready handshake.
- Decode or execute redirects it for taken branches, jal and jr.
- Sits between InstructionMemory and the IF/ID register. It replaces free-running PC logic so decode back-pressure never drops or duplicates an instruction.

Parameters:
- DEPTH, 2, fetch-buffer entries (power of two, ≥2).
- RESET_PC, 32'h00000000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  32  address to InstructionMemory; equals the PC register.
- imem_data  in  32  instruction returned combinationally for imem_addr.
- redirect_valid  in  1  taken branch/jump this cycle.
- redirect_pc  in  32  target address; bits [1:0] ignored.
- out_valid  out  1  buffer head holds a valid instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  32  head instruction word.
- out_pc  out  32  address of the head instruction.
- out_pc_plus4  out  32  out_pc + 4, modulo 2^32 (link value for jal).
- flush_count  out  16  number of redirects since reset, saturating at 16'hFFFF.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values:
  - PC = RESET_PC; imem_addr tracks PC.
  - Buffer empty (count = 0, read and write pointers = 0).
  - out_valid = 0, out_instr = 0, out_pc = 0, out_pc_plus4 = 4, flush_count = 0.
- Reset has priority over all other inputs. A reset asserted mid-stream discards all buffered entries at the next edge.
- pop = out_valid && out_ready.
- push = !reset && !redirect_valid && (count < DEPTH || pop).
- On push:
  - Write {PC, imem_data} at the write pointer.
  - PC <= PC + 4, 32-bit wrap: 32'hFFFFFFFC becomes 32'h00000000.
- On redirect_valid (and no reset):
  - Buffer flushed; count = 0 and both pointers cleared at the edge.
  - PC <= {redirect_pc[31:2], 2'b00}; no push that cycle.
  - flush_count increments, saturating.
- out_valid = (count != 0) && !redirect_valid. This combinational mask guarantees no handshake completes in a redirect cycle, and any same-cycle out_ready is ignored.
- When out_valid = 0, out_instr, out_pc and out_pc_plus4 hold their last head values. Consumers must not rely on them.
- Simultaneous push and pop at count = DEPTH is legal: count is unchanged and the pointers advance. count is never > DEPTH and never negative.
- Pointers wrap modulo DEPTH.
- Latency:
  - Fetch to out_valid: 1 cycle.
  - Redirect to first target instruction valid: 2 cycles. The target is fetched in the cycle after the redirect and is valid the cycle after that.
- Throughput: 1 instruction per cycle when out_ready is held high.
- Back-pressure: while out_ready = 0 and count = DEPTH, PC and imem_addr hold steady.
- No address range check: InstructionMemory decodes Address[9:2] and returns 0 (nop) outside its program.

Decomposition:
- Shared package mips_pkg holds:
  - INSTR_W = 32, ADDR_W = 32, PC_STEP = 4.
  - Opcode constants OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, plus RTYPE_FUNCT_JR = 6'h08. These are used by decode when forming redirects.
- One sub-module is natural: fetch_fifo (parameter DEPTH, WIDTH = 64). It provides push, pop, flush, count, and a combinational head read. ifetch_ctrl keeps the PC, redirect and counter logic.

Test Plan:
1. Reset, then out_ready = 1 for 6 cycles:
   - out_valid rises 1 cycle after reset deasserts.
   - out_pc = 0, 4, 8, … on consecutive cycles.
   - out_instr matches ROM word 0 = {6'h08, 5'd0, 5'd4, 16'd5}, then word 1, then word 2.
2. Back-pressure: out_ready = 0 for 5 cycles after reset:
   - count saturates at 2 and imem_addr holds at 8.
   - On release, out_pc = 0, 4, 8 in order; no duplicate, no gap.
3. Redirect with the buffer full:
   - redirect_pc = 32'h00000010 while out_ready = 1. out_valid = 0 that cycle.
   - flush_count = 1; next fetch address 0x10.
   - out_pc = 0x10 with instr {6'h08, 5'd29, 5'd29, 16'hFFF8} valid 2 cycles later.
4. Misaligned redirect: redirect_pc = 32'h00000017 → fetch at 0x14, out_pc = 0x14.
5. Wrap: RESET_PC = 32'hFFFFFFFC → out_pc = FFFFFFFC then 00000000; out_pc_plus4 = 0 for the first.
6. Reset mid-stream, with 2 entries buffered and PC = 0x20:
   - Pulse reset for 1 cycle → buffer empty, out_valid = 0, flush_count = 0.
   - Fetch resumes at RESET_PC.
